// File: rtl/rv32i_types_pkg.sv
// rv32i_types: shared encodings for the rv32i pipeline writeback path.
package rv32i_types;

    typedef enum logic [2:0] {
        WB_ALU  = 3'd0,
        WB_BR   = 3'd1,
        WB_UIMM = 3'd2,
        WB_LOAD = 3'd3,
        WB_PC4  = 3'd4
    } wb_sel_t;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    // MEM/WB pipeline register contents. wb_sel/funct3 are kept as raw bits
    // so that undefined encodings pass through to the default datapath.
    typedef struct packed {
        logic        valid;
        logic        load_regfile;
        logic [4:0]  rd;
        logic [2:0]  wb_sel;
        logic [2:0]  funct3;
        logic [31:0] alu_out;
        logic        br_en;
        logic [31:0] u_imm;
        logic [31:0] pc;
    } memwb_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// load_align: combinational byte/half extraction and sign/zero extension of
// the memory read word, plus detection of misaligned lw/lh/lhu offsets.
module load_align
    import rv32i_types::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] value,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/half, then extend according to funct3.
    always_comb begin
        byte_sel   = word[{offset, 3'b000} +: 8];
        half_sel   = offset[1] ? word[31:16] : word[15:0];
        value      = word;
        misaligned = 1'b0;
        case (funct3)
            lb:  value = {{24{byte_sel[7]}}, byte_sel};
            lbu: value = {24'd0, byte_sel};
            lh:  value = {{16{half_sel[15]}}, half_sel};
            lhu: value = {16'd0, half_sel};
            default: value = word;
        endcase
        if ((funct3 == lw) && (offset != 2'd0))
            misaligned = 1'b1;
        if (((funct3 == lh) || (funct3 == lhu)) && offset[0])
            misaligned = 1'b1;
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: rv32i writeback stage. Holds the MEM/WB register, selects the
// writeback value, and drives the register-file write port / forwarding bus.
// A 'done' bit makes a stalled instruction write and retire only once.
// Optional: define WB_INSTRET_EN to build the 64-bit retired-instruction
// counter and the instret output port.
module wb_stage
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        valid_in,
    input  logic        load_regfile_in,
    input  logic [4:0]  rd_in,
    input  logic [2:0]  wb_sel_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] alu_out_in,
    input  logic        br_en_in,
    input  logic [31:0] u_imm_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] data_value,
    input  logic [1:0]  mem_address_last_two_bits,
    output logic        regfile_we,
    output logic [4:0]  regfile_rd,
    output logic [31:0] regfile_wdata,
    output logic        retire,
    output logic        load_misaligned
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0] instret
`endif
);

    memwb_t      memwb_q, memwb_d;
    logic        done_q, done_d;
    logic        misaligned_q, misaligned_d;
    logic        active;
    logic [31:0] load_value;
    logic        load_mis;

    load_align u_load_align (
        .funct3     (memwb_q.funct3),
        .offset     (mem_address_last_two_bits),
        .word       (data_value),
        .value      (load_value),
        .misaligned (load_mis)
    );

    // Pipeline register update: load on advance, hold and mark done on stall.
    always_comb begin
        memwb_d = memwb_q;
        done_d  = done_q;
        if (stall) begin
            if (memwb_q.valid)
                done_d = 1'b1;
        end else begin
            memwb_d.valid        = valid_in & ~flush;
            memwb_d.load_regfile = load_regfile_in;
            memwb_d.rd           = rd_in;
            memwb_d.wb_sel       = wb_sel_in;
            memwb_d.funct3       = funct3_in;
            memwb_d.alu_out      = alu_out_in;
            memwb_d.br_en        = br_en_in;
            memwb_d.u_imm        = u_imm_in;
            memwb_d.pc           = pc_in;
            done_d               = 1'b0;
        end
    end

    // Writeback value select and write/retire qualification.
    always_comb begin
        active     = memwb_q.valid & ~done_q;
        retire     = active;
        regfile_we = active & memwb_q.load_regfile & (memwb_q.rd != 5'd0);
        regfile_rd = memwb_q.rd;
        case (memwb_q.wb_sel)
            WB_BR:   regfile_wdata = {31'd0, memwb_q.br_en};
            WB_UIMM: regfile_wdata = memwb_q.u_imm;
            WB_PC4:  regfile_wdata = memwb_q.pc + 32'd4;
            WB_LOAD: regfile_wdata = load_value;
            default: regfile_wdata = memwb_q.alu_out;
        endcase
        misaligned_d = misaligned_q |
                       (active & (memwb_q.wb_sel == WB_LOAD) & load_mis);
    end

    assign load_misaligned = misaligned_q;

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            memwb_q      <= '0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            memwb_q      <= memwb_d;
            done_q       <= done_d;
            misaligned_q <= misaligned_d;
        end
    end

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q, instret_d;

    // Retired-instruction counter, free-running wrap.
    always_comb begin
        instret_d = instret_q + {63'd0, retire};
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) instret_q <= '0;
        else      instret_q <= instret_d;
    end

    assign instret = instret_q;
`endif

endmodule
